ram_arbiter_rr: RTL and testbench

N-port generalisation of the data/program RAM multiplexer. It arbitrates up to NPORTS req/gnt/rvalid masters onto one single-port synchronous RAM (1-cycle read latency). Arbitration is selectable between round-robin and fixed priority. It sits between the core, plus future masters such as a debug or DMA port, and mem_data/mem_prog.

---
 rtl/ram_arbiter_rr_if.sv | 38 +++
 rtl/ram_arbiter_rr.sv | 93 +++++++++
 tb/tb_ram_arbiter_rr.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_rr_if.sv
// Master-side bus of the RAM arbiter: packed per-port request/grant/response lanes.
// The arbiter connects through the slave modport, the requesting masters through master.
interface ram_arbiter_rr_if #(
    parameter int NPORTS     = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [NPORTS-1:0]              port_req_i;
    logic [NPORTS-1:0]              port_gnt_o;
    logic [NPORTS-1:0]              port_rvalid_o;
    logic [NPORTS*ADDR_WIDTH-1:0]   port_addr_i;
    logic [NPORTS-1:0]              port_we_i;
    logic [NPORTS*DATA_WIDTH/8-1:0] port_be_i;
    logic [NPORTS*DATA_WIDTH-1:0]   port_wdata_i;
    logic [DATA_WIDTH-1:0]          port_rdata_o;

    modport master (
        output port_req_i,
        output port_addr_i,
        output port_we_i,
        output port_be_i,
        output port_wdata_i,
        input  port_gnt_o,
        input  port_rvalid_o,
        input  port_rdata_o
    );

    modport slave (
        input  port_req_i,
        input  port_addr_i,
        input  port_we_i,
        input  port_be_i,
        input  port_wdata_i,
        output port_gnt_o,
        output port_rvalid_o,
        output port_rdata_o
    );
endinterface

// File: rtl/ram_arbiter_rr.sv
// N-port arbiter (round-robin or fixed priority) onto one single-port synchronous RAM
// with one-cycle read latency; grant is combinational, rvalid follows one cycle later.
module ram_arbiter_rr #(
    parameter int NPORTS     = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RR_MODE    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    ram_arbiter_rr_if.slave         port_if,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);
    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int IDX_WIDTH = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_RST = IDX_WIDTH'(NPORTS - 1);

    logic [IDX_WIDTH-1:0] last_q;
    logic [IDX_WIDTH-1:0] last_d;
    logic [NPORTS-1:0]    rsel_q;
    logic [NPORTS-1:0]    rsel_d;
    logic                 found_s;
    logic [IDX_WIDTH-1:0] found_idx_s;
    logic                 gnt_any_s;
    logic [IDX_WIDTH-1:0] gnt_idx_s;
    logic [NPORTS-1:0]    gnt_s;

    // Priority search: rotating start after last_q, or plain ascending order.
    always_comb begin : arb_search
        logic [IDX_WIDTH-1:0] cand;
        logic                 hit;
        found_s     = 1'b0;
        found_idx_s = '0;
        cand        = '0;
        hit         = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            cand        = (RR_MODE != 0) ? IDX_WIDTH'((int'(last_q) + 1 + i) % NPORTS)
                                         : IDX_WIDTH'(i);
            hit         = port_if.port_req_i[cand] && !found_s;
            found_idx_s = hit ? cand : found_idx_s;
            found_s     = found_s || hit;
        end
    end

    // Reset suppresses any grant so the RAM sees no access while rst is high.
    always_comb begin : gnt_decode
        gnt_any_s = found_s && !rst;
        gnt_idx_s = found_idx_s;
        gnt_s     = '0;
        for (int k = 0; k < NPORTS; k++) begin
            gnt_s[k] = gnt_any_s && (gnt_idx_s == IDX_WIDTH'(k));
        end
    end

    // Route the granted port onto the RAM; idle cycles drive all-zero.
    always_comb begin : ram_mux
        ram_en_o    = gnt_any_s;
        ram_addr_o  = gnt_any_s ? port_if.port_addr_i[int'(gnt_idx_s)*ADDR_WIDTH +: ADDR_WIDTH]
                                : '0;
        ram_we_o    = gnt_any_s && port_if.port_we_i[gnt_idx_s];
        ram_be_o    = gnt_any_s ? port_if.port_be_i[int'(gnt_idx_s)*BE_WIDTH +: BE_WIDTH]
                                : '0;
        ram_wdata_o = gnt_any_s ? port_if.port_wdata_i[int'(gnt_idx_s)*DATA_WIDTH +: DATA_WIDTH]
                                : '0;
    end

    // Next-state: pointer moves only on a grant; response select tracks the grant.
    always_comb begin : next_state
        last_d = ((RR_MODE != 0) && gnt_any_s) ? gnt_idx_s : last_q;
        rsel_d = gnt_s;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin : state_regs
        if (rst) begin
            last_q <= LAST_RST;
            rsel_q <= '0;
        end else begin
            last_q <= last_d;
            rsel_q <= rsel_d;
        end
    end

    assign port_if.port_gnt_o    = gnt_s;
    // A response whose slot coincides with reset is dropped.
    assign port_if.port_rvalid_o = rst ? '0 : rsel_q;
    assign port_if.port_rdata_o  = ram_rdata_i;
endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Self-checking bench for ram_arbiter_rr: table-driven vectors on a round-robin instance
// with a read-data scoreboard, plus hand sequences for byte enables, reset and fixed priority.
module tb_ram_arbiter_rr;
    localparam int NP = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int NV = 20;

    typedef struct packed {
        logic          rst;
        logic [NP-1:0] req;
        logic [NP-1:0] we;
        logic [AW-1:0] base;
        logic [NP-1:0] exp_gnt;
    } vec_t;

    typedef struct {
        logic [NP-1:0] rv;
        logic          rd;
        logic [DW-1:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    logic ram_init;
    always #5 clk = ~clk;

    ram_arbiter_rr_if #(.NPORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rr_if ();
    ram_arbiter_rr_if #(.NPORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fp_if ();

    logic          rr_en, rr_we, fp_en, fp_we;
    logic [AW-1:0] rr_addr, fp_addr;
    logic [BW-1:0] rr_be, fp_be;
    logic [DW-1:0] rr_wdata, fp_wdata;
    logic [DW-1:0] rr_rdata;
    logic [DW-1:0] fp_rdata;

    ram_arbiter_rr #(.NPORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .port_if(rr_if.slave),
        .ram_en_o(rr_en), .ram_addr_o(rr_addr), .ram_we_o(rr_we), .ram_be_o(rr_be),
        .ram_wdata_o(rr_wdata), .ram_rdata_i(rr_rdata)
    );

    ram_arbiter_rr #(.NPORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0)) u_fp (
        .clk(clk), .rst(rst), .port_if(fp_if.slave),
        .ram_en_o(fp_en), .ram_addr_o(fp_addr), .ram_we_o(fp_we), .ram_be_o(fp_be),
        .ram_wdata_o(fp_wdata), .ram_rdata_i(fp_rdata)
    );

    assign fp_rdata = '0;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {6'h2A, a, 6'h15, a};
    endfunction

    function automatic logic [DW-1:0] wd(input logic [AW-1:0] base, input int k);
        return {8'hC0, 6'(k), base, 8'hD0};
    endfunction

    // Behavioural single-port RAM, one-cycle read latency, byte-masked writes.
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(10'(i));
        end else if (rr_en) begin
            if (rr_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (rr_be[b]) mem[rr_addr][b*8 +: 8] <= rr_wdata[b*8 +: 8];
                end
            end else begin
                rr_rdata <= mem[rr_addr];
            end
        end
    end

    logic [DW-1:0] shadow [0:1023];
    sb_t           sbq [$];
    vec_t          vt [NV];
    logic [DW-1:0] last_rdata;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [NP-1:0] req, input logic [NP-1:0] we,
                         input logic [NP*AW-1:0] a, input logic [NP*BW-1:0] be,
                         input logic [NP*DW-1:0] w, input logic [NP-1:0] exp_gnt,
                         input string nm);
        sb_t     e;
        sb_t     n;
        int      gi;
        logic [AW-1:0] ga;
        @(negedge clk);
        rst                = r;
        rr_if.port_req_i   = req;
        rr_if.port_we_i    = we;
        rr_if.port_addr_i  = a;
        rr_if.port_be_i    = be;
        rr_if.port_wdata_i = w;
        #4;
        chk({nm, " gnt"}, 32'(rr_if.port_gnt_o), 32'(exp_gnt));
        chk({nm, " ram_en"}, 32'(rr_en), 32'(|exp_gnt));
        gi = -1;
        for (int k = 0; k < NP; k++) if (exp_gnt[k]) gi = k;
        if (gi >= 0) begin
            ga = a[gi*AW +: AW];
            chk({nm, " ram_addr"}, 32'(rr_addr), 32'(ga));
            chk({nm, " ram_we"}, 32'(rr_we), 32'(we[gi]));
            if (we[gi]) begin
                chk({nm, " ram_be"}, 32'(rr_be), 32'(be[gi*BW +: BW]));
                chk({nm, " ram_wdata"}, rr_wdata, w[gi*DW +: DW]);
            end
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({nm, " rvalid"}, 32'(rr_if.port_rvalid_o), r ? 32'(0) : 32'(e.rv));
            if (!r && e.rd) chk({nm, " rdata"}, rr_if.port_rdata_o, e.data);
            last_rdata = rr_if.port_rdata_o;
        end
        n.rv   = exp_gnt;
        n.rd   = 1'b0;
        n.data = '0;
        if (gi >= 0) begin
            if (we[gi]) begin
                for (int b = 0; b < BW; b++) begin
                    if (be[gi*BW + b]) shadow[ga][b*8 +: 8] = w[gi*DW + b*8 +: 8];
                end
            end else begin
                n.rd   = 1'b1;
                n.data = shadow[ga];
            end
        end
        sbq.push_back(n);
    endtask

    task automatic fp_step(input logic [NP-1:0] req, input logic [NP-1:0] exp_gnt,
                           input logic [NP-1:0] exp_rv, input string nm);
        @(negedge clk);
        fp_if.port_req_i = req;
        #4;
        chk({nm, " gnt"}, 32'(fp_if.port_gnt_o), 32'(exp_gnt));
        chk({nm, " rvalid"}, 32'(fp_if.port_rvalid_o), 32'(exp_rv));
        chk({nm, " ram_en"}, 32'(fp_en), 32'(|exp_gnt));
    endtask

    initial begin
        logic [NP*AW-1:0] a;
        logic [NP*BW-1:0] be;
        logic [NP*DW-1:0] w;

        // rst, req, we, base, expected grant
        vt[0]  = '{1'b1, 4'hF, 4'h0, 10'h000, 4'b0000};
        vt[1]  = '{1'b1, 4'hF, 4'h0, 10'h000, 4'b0000};
        vt[2]  = '{1'b0, 4'h4, 4'h0, 10'h003, 4'b0100};
        vt[3]  = '{1'b0, 4'h0, 4'h0, 10'h000, 4'b0000};
        vt[4]  = '{1'b0, 4'h0, 4'h0, 10'h000, 4'b0000};
        vt[5]  = '{1'b0, 4'h0, 4'h0, 10'h000, 4'b0000};
        vt[6]  = '{1'b0, 4'hD, 4'h0, 10'h020, 4'b1000};
        vt[7]  = '{1'b0, 4'hD, 4'h0, 10'h020, 4'b0001};
        vt[8]  = '{1'b0, 4'hD, 4'h0, 10'h020, 4'b0100};
        vt[9]  = '{1'b1, 4'hF, 4'h0, 10'h000, 4'b0000};
        vt[10] = '{1'b0, 4'hF, 4'h5, 10'h100, 4'b0001};
        vt[11] = '{1'b0, 4'hF, 4'h5, 10'h110, 4'b0010};
        vt[12] = '{1'b0, 4'hF, 4'h5, 10'h120, 4'b0100};
        vt[13] = '{1'b0, 4'hF, 4'h5, 10'h130, 4'b1000};
        vt[14] = '{1'b0, 4'hF, 4'h5, 10'h140, 4'b0001};
        vt[15] = '{1'b0, 4'hF, 4'h5, 10'h100, 4'b0010};
        vt[16] = '{1'b0, 4'hF, 4'h5, 10'h11E, 4'b0100};
        vt[17] = '{1'b0, 4'hF, 4'h5, 10'h11D, 4'b1000};
        vt[18] = '{1'b0, 4'h2, 4'h0, 10'h0FF, 4'b0010};
        vt[19] = '{1'b0, 4'h0, 4'h0, 10'h000, 4'b0000};

        rst                = 1'b1;
        ram_init           = 1'b1;
        last_rdata         = '0;
        rr_if.port_req_i   = '0;
        rr_if.port_we_i    = '0;
        rr_if.port_addr_i  = '0;
        rr_if.port_be_i    = '0;
        rr_if.port_wdata_i = '0;
        fp_if.port_req_i   = '0;
        fp_if.port_we_i    = '0;
        fp_if.port_addr_i  = '0;
        fp_if.port_be_i    = '0;
        fp_if.port_wdata_i = '0;
        for (int i = 0; i < 1024; i++) shadow[i] = pat(10'(i));
        @(posedge clk);
        #1 ram_init = 1'b0;

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < NP; k++) begin
                a[k*AW +: AW]  = vt[i].base + AW'(k);
                be[k*BW +: BW] = 4'hF;
                w[k*DW +: DW]  = wd(vt[i].base, k);
            end
            apply(vt[i].rst, vt[i].req, vt[i].we, a, be, w, vt[i].exp_gnt,
                  $sformatf("vec%0d", i));
        end

        // Byte-enable merge: full write, partial write, read-back by another port.
        a = '0; be = '0; w = '0;
        a[0*AW +: AW] = 10'h010; be[0*BW +: BW] = 4'hF; w[0*DW +: DW] = 32'hAABBCCDD;
        a[1*AW +: AW] = 10'h010; be[1*BW +: BW] = 4'h3; w[1*DW +: DW] = 32'h11223344;
        a[3*AW +: AW] = 10'h010;
        apply(1'b0, 4'b0001, 4'b0001, a, be, w, 4'b0001, "be_wr_p0");
        apply(1'b0, 4'b0010, 4'b0010, a, be, w, 4'b0010, "be_wr_p1");
        apply(1'b0, 4'b1000, 4'b0000, a, be, w, 4'b1000, "be_rd_p3");
        apply(1'b0, 4'b0000, 4'b0000, a, be, w, 4'b0000, "be_idle");
        chk("be_merge", last_rdata, 32'hAABB3344);

        // Reset right after a grant drops the response and restores port-0 priority.
        apply(1'b0, 4'b0010, 4'b0000, a, be, w, 4'b0010, "mr_gnt");
        apply(1'b1, 4'b1001, 4'b0000, a, be, w, 4'b0000, "mr_rst");
        apply(1'b0, 4'b1001, 4'b0000, a, be, w, 4'b0001, "mr_first");
        apply(1'b0, 4'b0000, 4'b0000, a, be, w, 4'b0000, "mr_idle");

        // Fixed priority: port 1 starves port 3 until it drops its request.
        fp_step(4'b1010, 4'b0010, 4'b0000, "fp_0");
        fp_step(4'b1010, 4'b0010, 4'b0010, "fp_1");
        fp_step(4'b1010, 4'b0010, 4'b0010, "fp_2");
        fp_step(4'b1010, 4'b0010, 4'b0010, "fp_3");
        fp_step(4'b1000, 4'b1000, 4'b0010, "fp_drop");
        fp_step(4'b0000, 4'b0000, 4'b1000, "fp_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
